// File: rtl/adder32_bist.sv
// adder32_bist: stimulus generator and result checker for a WIDTH-bit adder
module adder32_bist #(
    parameter int WIDTH = 32,
    parameter int NUM_VECTORS = 256,
    parameter int SETTLE_CYCLES = 2,
    parameter logic [31:0] SEED_A = 32'hACE1_2468,
    parameter logic [31:0] SEED_B = 32'h1357_BDF0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_ci,
    input  logic [WIDTH-1:0] dut_s,
    input  logic             dut_co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail_idx,
    output logic [15:0]      vec_count
);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, DONE} state_t;
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003);
    state_t state, state_nx;
    logic [WIDTH-1:0] lfsr_a, lfsr_b, op_a, op_b;
    logic op_ci, go, last, settle_done, mismatch;
    logic [WIDTH:0] exp_sum;
    logic [15:0] settle_cnt;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    assign go = start & ~busy;
    assign last = vec_count == 16'(NUM_VECTORS - 1);
    assign settle_done = settle_cnt == 16'(SETTLE_CYCLES - 1);
    assign mismatch = (dut_s != exp_sum[WIDTH-1:0]) | (dut_co != exp_sum[WIDTH]);

    // Operand source: four directed corner vectors, then the two LFSRs
    always_comb begin
        op_a = lfsr_a;
        op_b = lfsr_b;
        op_ci = lfsr_a[WIDTH-1] ^ lfsr_b[0];
        case (vec_count)
            16'd0: begin op_a = WIDTH'(5); op_b = WIDTH'(10); op_ci = 1'b1; end
            16'd1: begin op_a = WIDTH'(10); op_b = WIDTH'(33); op_ci = 1'b0; end
            16'd2: begin op_a = WIDTH'(641322); op_b = WIDTH'(542343); op_ci = 1'b0; end
            16'd3: begin op_a = '1; op_b = WIDTH'(1); op_ci = 1'b0; end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? LOAD : IDLE;
            LOAD:    state_nx = SETTLE;
            SETTLE:  state_nx = settle_done ? CHECK : SETTLE;
            CHECK:   state_nx = last ? DONE : LOAD;
            DONE:    state_nx = go ? LOAD : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand, reference, counter and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_a <= '0;
            dut_b <= '0;
            dut_ci <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_fail_idx <= 16'hFFFF;
            vec_count <= '0;
            lfsr_a <= WIDTH'(SEED_A);
            lfsr_b <= WIDTH'(SEED_B);
            exp_sum <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        busy <= 1'b1;
                        done <= 1'b0;
                        pass <= 1'b0;
                        err_count <= '0;
                        first_fail_idx <= 16'hFFFF;
                        vec_count <= '0;
                        lfsr_a <= WIDTH'(SEED_A);
                        lfsr_b <= WIDTH'(SEED_B);
                    end else if (state == DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= err_count == 16'd0;
                    end
                end
                LOAD: begin
                    dut_a <= op_a;
                    dut_b <= op_b;
                    dut_ci <= op_ci;
                    exp_sum <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_ci};
                    settle_cnt <= '0;
                end
                SETTLE: settle_cnt <= settle_cnt + 16'd1;
                CHECK: begin
                    if (mismatch) begin
                        err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
                        first_fail_idx <= (first_fail_idx == 16'hFFFF) ? vec_count : first_fail_idx;
                    end
                    if (!last) begin
                        vec_count <= vec_count + 16'd1;
                        if (vec_count >= 16'd4) begin
                            lfsr_a <= lfsr_step(lfsr_a);
                            lfsr_b <= lfsr_step(lfsr_b);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
